initial_logic: RTL and testbench
================================

INITIAL_LOGIC -- requirements
Module: initial_logic

Interface
REQ-001 Parameter VC_SEL_BIT, default 4: bit index of the input word that selects the destination virtual channel (0 -> VC0, 1 -> VC1).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_L  input  1  reset, synchronous and active-low.
REQ-004 data_in_main  input  6  head word of the main input FIFO; first-word fall-through, valid whenever empty_main=0.
REQ-005 empty_main  input  1  main FIFO empty.
REQ-006 almost_full_VC0 / almost_full_VC1  input  1 each  VC FIFO has at most one free slot.
REQ-007 full_VC0 / full_VC1  input  1 each  VC FIFO has no free slot.
REQ-008 pop_main  output  1  consume the head word of the main FIFO this cycle.
REQ-009 push_VC0 / push_VC1  output  1 each  write data_out_VCx into the VC FIFO this cycle.
REQ-010 data_out_VC0 / data_out_VC1  output  6 each  registered word presented to the VC FIFO.
REQ-011 error  output  1  sticky overflow flag.
REQ-012 idle  output  1  high while the FSM is in IDLE.
REQ-013 state  output  2  FSM state encoding: RESET=00, IDLE=01, ACTIVE=10, ERROR=11.
REQ-014 count_VC0 / count_VC1  output  8 each  number of words pushed to each VC.

Function
REQ-015 dest SHALL equal data_in_main[VC_SEL_BIT].
- pop_main SHALL be combinational: state==ACTIVE & !empty_main & !almost_full_VC[dest].
REQ-016 On a cycle with pop_main=1, at the next rising edge:
- data_in_main SHALL be registered into data_out_VC[dest].
- push_VC[dest] SHALL be set to 1.
- The push therefore follows the pop by exactly one cycle.
REQ-017 push_VCx SHALL be 1 for exactly one cycle per popped word.
- push_VC0 and push_VC1 SHALL never both be 1 in the same cycle.
REQ-018 data_out_VCx SHALL hold its last value when no word is routed to that VC.
REQ-019 Back-to-back pops SHALL be allowed, giving one word per cycle.
- A VC whose almost_full is high SHALL block pop_main only while the head word targets that VC.
- Head-of-line blocking is intended: no reordering.
REQ-020 count_VCx SHALL increment by 1 on each push_VCx and wrap 255 -> 0.
REQ-021 FSM transitions:
- RESET -> IDLE on the first clock with reset_L=1.
- IDLE -> ACTIVE when empty_main=0.
- ACTIVE -> IDLE when empty_main=1 and no push is pending in the next cycle.
- Any state -> ERROR on overflow.
- ERROR SHALL be left only by reset.
REQ-022 Overflow SHALL be detected when push_VCx=1 while full_VCx=1.
- On overflow, error SHALL go to 1 at the next edge and stay 1.
- On overflow, pop_main SHALL be forced to 0.
- On overflow, counters SHALL freeze.
REQ-023 When empty_main rises in the same cycle as a pop, the pop SHALL NOT occur.
- The FSM SHALL complete the pending push and then go to IDLE.
REQ-024 When almost_full of the destination rises in the same cycle as a potential pop, no pop SHALL occur.

Reset
REQ-025 While reset_L=0 at a rising edge, the block SHALL set:
- state=RESET
- push_VC0=push_VC1=0
- data_out_VC0=data_out_VC1=0
- count_VC0=count_VC1=0
- error=0
- idle=0
REQ-026 pop_main SHALL be 0 whenever state!=ACTIVE, including during reset.
REQ-027 Reset asserted mid-transfer SHALL discard any pending push; no push SHALL appear after the reset edge.

Verification
REQ-028 Reset: reset_L=0 for 2 cycles, then 1 -> all outputs 0 during reset; state=01, idle=1 one cycle after release.
REQ-029 Routing: main FIFO holds 0x34 (bit4=1), 0x25 (bit4=0), no almost_full/full -> pop_main for 2 consecutive cycles; push_VC1 with data_out_VC1=0x34, then push_VC0 with data_out_VC0=0x25; count_VC1=1, count_VC0=1.
REQ-030 Backpressure: head 0x36 (VC1), almost_full_VC1=1 for 3 cycles -> pop_main=0 for those 3 cycles; pop in the cycle after almost_full_VC1 drops; push_VC1 one cycle later.
REQ-031 Empty race: empty_main goes 1 in the same cycle as a candidate pop -> no pop; the pending push completes; state returns to 01.
REQ-032 Overflow: full_VC0 forced 1 while push_VC0=1 -> error=1 and state=11 at the next edge; pop_main stays 0 until reset_L=0 clears the error.
REQ-033 Counter wrap: 256 words routed to VC0 -> count_VC0 reads 255 after the 255th push and 0 after the 256th.

Source files
------------

// File: rtl/initial_logic_if.sv
// Bus between the routing block, the main input FIFO and the two VC FIFOs.
// The master modport is the routing block; the slave modport is the FIFO/status side.
interface initial_logic_if;
    logic [5:0] data_in_main;
    logic       empty_main;
    logic       almost_full_VC0;
    logic       almost_full_VC1;
    logic       full_VC0;
    logic       full_VC1;
    logic       pop_main;
    logic       push_VC0;
    logic       push_VC1;
    logic [5:0] data_out_VC0;
    logic [5:0] data_out_VC1;
    logic       error;
    logic       idle;
    logic [1:0] state;
    logic [7:0] count_VC0;
    logic [7:0] count_VC1;

    modport master (
        input  data_in_main, empty_main, almost_full_VC0, almost_full_VC1, full_VC0, full_VC1,
        output pop_main, push_VC0, push_VC1, data_out_VC0, data_out_VC1,
        output error, idle, state, count_VC0, count_VC1
    );

    modport slave (
        output data_in_main, empty_main, almost_full_VC0, almost_full_VC1, full_VC0, full_VC1,
        input  pop_main, push_VC0, push_VC1, data_out_VC0, data_out_VC1,
        input  error, idle, state, count_VC0, count_VC1
    );
endinterface

// File: rtl/initial_logic.sv
// Routes words from the main FIFO to one of two VC FIFOs, selected by one bit of each word.
// Push follows pop by one cycle; an overflow locks the block in ERROR until reset.
module initial_logic #(
    parameter int unsigned VC_SEL_BIT = 4
) (
    input logic            clk,
    input logic            reset_L,
    initial_logic_if.master bus
);

    typedef enum logic [1:0] {
        StReset  = 2'b00,
        StIdle   = 2'b01,
        StActive = 2'b10,
        StError  = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic       push_vc0_q, push_vc0_d;
    logic       push_vc1_q, push_vc1_d;
    logic [5:0] data_vc0_q, data_vc0_d;
    logic [5:0] data_vc1_q, data_vc1_d;
    logic [7:0] count_vc0_q, count_vc0_d;
    logic [7:0] count_vc1_q, count_vc1_d;
    logic       error_q, error_d;
    logic       idle_q, idle_d;

    logic dest;
    logic af_dest;
    logic overflow;
    logic pop;

    assign dest     = bus.data_in_main[VC_SEL_BIT];
    assign af_dest  = dest ? bus.almost_full_VC1 : bus.almost_full_VC0;
    assign overflow = (push_vc0_q & bus.full_VC0) | (push_vc1_q & bus.full_VC1);
    assign pop      = (state_q == StActive) & ~bus.empty_main & ~af_dest & ~overflow;

    always_comb begin
        state_d     = state_q;
        push_vc0_d  = 1'b0;
        push_vc1_d  = 1'b0;
        data_vc0_d  = data_vc0_q;
        data_vc1_d  = data_vc1_q;
        count_vc0_d = count_vc0_q;
        count_vc1_d = count_vc1_q;
        error_d     = error_q | overflow;

        if (pop) begin
            if (dest) begin
                push_vc1_d = 1'b1;
                data_vc1_d = bus.data_in_main;
            end else begin
                push_vc0_d = 1'b1;
                data_vc0_d = bus.data_in_main;
            end
        end

        // Counters track completed pushes and freeze on the overflowing one.
        if (!overflow) begin
            if (push_vc0_q) count_vc0_d = count_vc0_q + 8'd1;
            if (push_vc1_q) count_vc1_d = count_vc1_q + 8'd1;
        end

        unique case (state_q)
            StReset:  state_d = StIdle;
            StIdle:   if (!bus.empty_main) state_d = StActive;
            StActive: if (bus.empty_main) state_d = StIdle;
            StError:  state_d = StError;
        endcase

        if (overflow) state_d = StError;

        idle_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q     <= StReset;
            push_vc0_q  <= 1'b0;
            push_vc1_q  <= 1'b0;
            data_vc0_q  <= 6'h00;
            data_vc1_q  <= 6'h00;
            count_vc0_q <= 8'h00;
            count_vc1_q <= 8'h00;
            error_q     <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            push_vc0_q  <= push_vc0_d;
            push_vc1_q  <= push_vc1_d;
            data_vc0_q  <= data_vc0_d;
            data_vc1_q  <= data_vc1_d;
            count_vc0_q <= count_vc0_d;
            count_vc1_q <= count_vc1_d;
            error_q     <= error_d;
            idle_q      <= idle_d;
        end
    end

    assign bus.pop_main     = pop;
    assign bus.push_VC0     = push_vc0_q;
    assign bus.push_VC1     = push_vc1_q;
    assign bus.data_out_VC0 = data_vc0_q;
    assign bus.data_out_VC1 = data_vc1_q;
    assign bus.count_VC0    = count_vc0_q;
    assign bus.count_VC1    = count_vc1_q;
    assign bus.error        = error_q;
    assign bus.idle         = idle_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_initial_logic.sv
// Bench for initial_logic: a queue-based main FIFO and scoreboard drive and check the block
// cycle by cycle, plus a pop-decision vector table and directed corner-case sequences.
module tb_initial_logic;

    localparam int SEL       = 4;
    localparam int ST_RESET  = 0;
    localparam int ST_IDLE   = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_ERROR  = 3;

    logic clk;
    logic reset_L;

    initial_logic_if bus ();

    initial_logic #(.VC_SEL_BIT(SEL)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: main FIFO contents, words owed to each VC, and the expected FSM mode.
    logic [5:0] main_q[$];
    logic [5:0] exp_vc0_q[$];
    logic [5:0] exp_vc1_q[$];
    logic       exp_push0, exp_push1;
    int         pushes0, pushes1;
    int         mst;
    logic       err_m;
    logic       af0, af1, full0, full1;
    logic       obs_pop, obs_push0, obs_push1;

    typedef struct {
        logic [5:0] data;
        logic       empty;
        logic       af0;
        logic       af1;
        logic       exp_pop;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        reset_L              = 1'b0;
        bus.empty_main       = 1'b0;
        bus.data_in_main     = 6'h34;
        bus.almost_full_VC0  = 1'b0;
        bus.almost_full_VC1  = 1'b0;
        bus.full_VC0         = 1'b0;
        bus.full_VC1         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        if (chk) begin
            check("rst_state", bus.state, 0);
            check("rst_pop", bus.pop_main, 0);
            check("rst_push", {bus.push_VC0, bus.push_VC1}, 0);
            check("rst_data", {bus.data_out_VC0, bus.data_out_VC1}, 0);
            check("rst_count", {bus.count_VC0, bus.count_VC1}, 0);
            check("rst_error", bus.error, 0);
            check("rst_idle", bus.idle, 0);
        end
        reset_L        = 1'b1;
        bus.empty_main = 1'b1;
        @(posedge clk);
        main_q.delete();
        exp_vc0_q.delete();
        exp_vc1_q.delete();
        exp_push0 = 1'b0;
        exp_push1 = 1'b0;
        pushes0   = 0;
        pushes1   = 0;
        mst       = ST_IDLE;
        err_m     = 1'b0;
        af0       = 1'b0;
        af1       = 1'b0;
        full0     = 1'b0;
        full1     = 1'b0;
        if (chk) begin
            @(negedge clk);
            #1;
            check("rel_state", bus.state, ST_IDLE);
            check("rel_idle", bus.idle, 1);
        end
    endtask

    // One clock of the FIFO model: drive, check the DUT against the reference, advance.
    task automatic step();
        logic       dest, exp_pop, ovf, p0, p1, pop, empty;
        logic [5:0] w;
        @(negedge clk);
        empty               = (main_q.size() == 0);
        bus.empty_main      = empty;
        bus.data_in_main    = empty ? 6'h00 : main_q[0];
        bus.almost_full_VC0 = af0;
        bus.almost_full_VC1 = af1;
        bus.full_VC0        = full0;
        bus.full_VC1        = full1;
        #1;
        dest    = bus.data_in_main[SEL];
        p0      = bus.push_VC0;
        p1      = bus.push_VC1;
        pop     = bus.pop_main;
        ovf     = (p0 && full0) || (p1 && full1);
        exp_pop = (mst == ST_ACTIVE) && !empty && !(dest ? af1 : af0) && !ovf;

        check("state", bus.state, mst);
        check("idle", bus.idle, mst == ST_IDLE);
        check("error", bus.error, err_m);
        check("pop_main", pop, exp_pop);
        check("push_VC0", p0, exp_push0);
        check("push_VC1", p1, exp_push1);
        check("push_exclusive", p0 && p1, 0);
        check("count_VC0", bus.count_VC0, pushes0 % 256);
        check("count_VC1", bus.count_VC1, pushes1 % 256);
        if (p0 && exp_vc0_q.size() != 0) check("data_out_VC0", bus.data_out_VC0, exp_vc0_q.pop_front());
        if (p1 && exp_vc1_q.size() != 0) check("data_out_VC1", bus.data_out_VC1, exp_vc1_q.pop_front());

        err_m = err_m || ovf;
        if (!ovf) begin
            pushes0 += int'(p0);
            pushes1 += int'(p1);
        end
        exp_push0 = exp_pop && !dest;
        exp_push1 = exp_pop && dest;
        if (pop && !empty) begin
            w = main_q.pop_front();
            if (dest) exp_vc1_q.push_back(w);
            else      exp_vc0_q.push_back(w);
        end
        if (ovf)                               mst = ST_ERROR;
        else if (mst == ST_IDLE && !empty)     mst = ST_ACTIVE;
        else if (mst == ST_ACTIVE && empty)    mst = ST_IDLE;
        obs_pop   = pop;
        obs_push0 = p0;
        obs_push1 = p1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (k < budget && (main_q.size() != 0 || exp_vc0_q.size() != 0 ||
                              exp_vc1_q.size() != 0 || exp_push0 || exp_push1)) begin
            step();
            k++;
        end
        check("drain_done", main_q.size() + exp_vc0_q.size() + exp_vc1_q.size() +
              int'(exp_push0) + int'(exp_push1), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        bit   saw255;
        vecs[0] = '{6'h34, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{6'h34, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{6'h34, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{6'h25, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{6'h25, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{6'h0F, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{6'h10, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{6'h00, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_L             = 1'b0;
        bus.empty_main      = 1'b1;
        bus.data_in_main    = 6'h00;
        bus.almost_full_VC0 = 1'b0;
        bus.almost_full_VC1 = 1'b0;
        bus.full_VC0        = 1'b0;
        bus.full_VC1        = 1'b0;

        do_reset(1'b1);

        // Routing of two words to opposite VCs, back to back.
        main_q.push_back(6'h34);
        main_q.push_back(6'h25);
        step();
        step();
        check("route_pop1", obs_pop, 1);
        step();
        check("route_pop2", obs_pop, 1);
        check("route_push1", obs_push1, 1);
        check("route_d1", bus.data_out_VC1, 6'h34);
        step();
        check("route_push0", obs_push0, 1);
        check("route_d0", bus.data_out_VC0, 6'h25);
        check("route_hold1", bus.data_out_VC1, 6'h34);
        step();
        check("route_cnt0", bus.count_VC0, 1);
        check("route_cnt1", bus.count_VC1, 1);
        check("route_idle", bus.state, ST_IDLE);

        // Pop decision table, applied while the FSM sits in ACTIVE.
        do_reset(1'b0);
        @(negedge clk);
        bus.empty_main      = 1'b0;
        bus.data_in_main    = 6'h0F;
        bus.almost_full_VC0 = 1'b1;
        bus.almost_full_VC1 = 1'b1;
        @(posedge clk);
        #1;
        check("tbl_active", bus.state, ST_ACTIVE);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.data_in_main    = vecs[i].data;
            bus.empty_main      = vecs[i].empty;
            bus.almost_full_VC0 = vecs[i].af0;
            bus.almost_full_VC1 = vecs[i].af1;
            #1;
            check($sformatf("tbl_pop[%0d]", i), bus.pop_main, vecs[i].exp_pop);
        end

        // Backpressure on VC1 for three cycles.
        do_reset(1'b0);
        main_q.push_back(6'h36);
        af1 = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_blocked", obs_pop, 0);
        end
        af1 = 1'b0;
        step();
        check("bp_pop", obs_pop, 1);
        step();
        check("bp_push", obs_push1, 1);

        // Empty race: FIFO runs dry right after a pop.
        do_reset(1'b0);
        main_q.push_back(6'h05);
        step();
        step();
        check("race_pop", obs_pop, 1);
        step();
        check("race_nopop", obs_pop, 0);
        check("race_push", obs_push0, 1);
        step();
        check("race_idle", bus.state, ST_IDLE);

        // Overflow on VC0 locks the block until reset.
        do_reset(1'b0);
        main_q.push_back(6'h01);
        main_q.push_back(6'h02);
        main_q.push_back(6'h03);
        step();
        step();
        full0 = 1'b1;
        step();
        check("ovf_push", obs_push0, 1);
        check("ovf_pop_forced", obs_pop, 0);
        full0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ovf_locked", obs_pop, 0);
        end
        check("ovf_state", bus.state, ST_ERROR);
        check("ovf_err", bus.error, 1);
        check("ovf_cnt_frozen", bus.count_VC0, 0);
        do_reset(1'b0);
        step();
        check("ovf_cleared", bus.error, 0);

        // Reset during a transfer discards the pending push.
        do_reset(1'b0);
        main_q.push_back(6'h11);
        step();
        @(negedge clk);
        bus.empty_main   = 1'b0;
        bus.data_in_main = 6'h11;
        #1;
        check("rstmid_pop", bus.pop_main, 1);
        reset_L = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid_nopush", {bus.push_VC0, bus.push_VC1}, 0);
        check("rstmid_state", bus.state, ST_RESET);

        // Counter wrap: 256 words to VC0.
        do_reset(1'b0);
        for (int i = 0; i < 256; i++) main_q.push_back(6'($urandom) & 6'h2F);
        saw255 = 1'b0;
        for (int k = 0; k < 400 && (main_q.size() != 0 || exp_vc0_q.size() != 0 || exp_push0); k++) begin
            step();
            if (bus.count_VC0 == 8'd255) saw255 = 1'b1;
        end
        step();
        check("wrap_saw255", saw255, 1);
        check("wrap_zero", bus.count_VC0, 0);

        // Random traffic with random almost_full on both VCs.
        do_reset(1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (main_q.size() < 16 && $urandom_range(0, 9) < 4) main_q.push_back(6'($urandom));
            af0 = ($urandom_range(0, 9) < 3);
            af1 = ($urandom_range(0, 9) < 3);
            step();
        end
        af0 = 1'b0;
        af1 = 1'b0;
        drain(200);
        step();
        check("rand_idle", bus.state, ST_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
